acq_trigger_ctrl: RTL and testbench

ACQ_TRIGGER_CTRL -- requirements
Module: acq_trigger_ctrl

---
 rtl/acq_pkg.sv | 28 ++
 rtl/acq_trigger_ctrl.sv | 159 +++++++++++++++
 tb/tb_acq_trigger_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/acq_pkg.sv
// Shared encodings for the acquisition trigger controller: FSM states, mode codes
// and the timeout counter width.
package acq_pkg;

  localparam int unsigned STATE_W   = 3;
  localparam int unsigned MODE_W    = 2;
  localparam int unsigned TIMEOUT_W = 32;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } acq_state_e;

  typedef enum logic [MODE_W-1:0] {
    MODE_SINGLE = 2'd0,
    MODE_NORMAL = 2'd1,
    MODE_AUTO   = 2'd2
  } acq_mode_e;

  // The unused code 3 falls back to single-shot behaviour.
  function automatic acq_mode_e decode_mode(input logic [MODE_W-1:0] m);
    decode_mode = (m == 2'd3) ? MODE_SINGLE : acq_mode_e'(m);
  endfunction

endpackage

// File: rtl/acq_trigger_ctrl.sv
// Acquisition sequencer: pre-trigger fill, trigger wait (edge or auto timeout),
// post-trigger capture and HPS done handshake, with optional automatic re-arm.
module acq_trigger_ctrl
  import acq_pkg::*;
#(
  parameter int unsigned MEMORY_ADDR_LEN = 32,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       arm,
  input  logic                       abort,
  input  logic [MODE_W-1:0]          mode,
  input  logic [CNT_WIDTH-1:0]       pre_samples,
  input  logic [CNT_WIDTH-1:0]       post_samples,
  input  logic [TIMEOUT_W-1:0]       auto_timeout,
  input  logic                       in_data_valid,
  input  logic                       trigger,
  input  logic [MEMORY_ADDR_LEN-1:0] in_dma_master_address,
  input  logic                       done_ack,
  output logic                       capture_en,
  output logic [MEMORY_ADDR_LEN-1:0] trig_addr,
  output logic                       trig_forced,
  output logic                       done,
  output logic                       busy,
  output logic [STATE_W-1:0]         state
);

  acq_state_e                 state_q, state_d;
  acq_mode_e                  mode_q, mode_d;
  logic [CNT_WIDTH-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [CNT_WIDTH-1:0]       pre_q, pre_d;
  logic [CNT_WIDTH-1:0]       post_q, post_d;
  logic [TIMEOUT_W-1:0]       tmo_q, tmo_d, tmo_inc;
  logic [TIMEOUT_W-1:0]       tmo_cfg_q, tmo_cfg_d;
  logic [MEMORY_ADDR_LEN-1:0] trig_addr_d;
  logic                       trig_forced_d;
  logic                       trig_prev_q;
  logic                       trig_edge;
  logic                       load_cfg;
  logic                       accept;
  logic                       accept_forced;

  assign cnt_inc   = CNT_WIDTH'(cnt_q + 1'b1);
  assign tmo_inc   = TIMEOUT_W'(tmo_q + 1'b1);
  assign trig_edge = trigger & ~trig_prev_q;
  assign state     = state_q;

  // Next-state, counters and configuration capture; abort overrides everything.
  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    cnt_d         = cnt_q;
    pre_d         = pre_q;
    post_d        = post_q;
    tmo_d         = tmo_q;
    tmo_cfg_d     = tmo_cfg_q;
    trig_addr_d   = trig_addr;
    trig_forced_d = trig_forced;
    load_cfg      = 1'b0;
    accept        = 1'b0;
    accept_forced = 1'b0;

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: load_cfg = arm;
        ST_PRE: begin
          if (in_data_valid) begin
            if (cnt_inc == pre_q) begin
              state_d = ST_WAIT;
              cnt_d   = '0;
              tmo_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        ST_WAIT: begin
          // A genuine edge wins over a timeout landing in the same cycle.
          if (trig_edge) begin
            accept = 1'b1;
          end else if (mode_q == MODE_AUTO && tmo_cfg_q != '0 && tmo_inc == tmo_cfg_q) begin
            accept        = 1'b1;
            accept_forced = 1'b1;
          end else begin
            tmo_d = tmo_inc;
          end
        end
        ST_POST: begin
          if (in_data_valid) begin
            if (cnt_inc == post_q) state_d = ST_DONE;
            else                   cnt_d   = cnt_inc;
          end
        end
        ST_DONE: begin
          if (done_ack) begin
            if (mode_q == MODE_SINGLE) state_d  = ST_IDLE;
            else                       load_cfg = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (accept) begin
        trig_addr_d   = in_dma_master_address;
        trig_forced_d = accept_forced;
        cnt_d         = '0;
        state_d       = (post_q == '0) ? ST_DONE : ST_POST;
      end

      // Arm and re-arm both snapshot the configuration for the coming acquisition.
      if (load_cfg) begin
        mode_d    = decode_mode(mode);
        pre_d     = pre_samples;
        post_d    = post_samples;
        tmo_cfg_d = auto_timeout;
        cnt_d     = '0;
        tmo_d     = '0;
        state_d   = (pre_samples == '0) ? ST_WAIT : ST_PRE;
      end
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_SINGLE;
      cnt_q       <= '0;
      pre_q       <= '0;
      post_q      <= '0;
      tmo_q       <= '0;
      tmo_cfg_q   <= '0;
      trig_prev_q <= 1'b0;
      trig_addr   <= '0;
      trig_forced <= 1'b0;
      capture_en  <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      pre_q       <= pre_d;
      post_q      <= post_d;
      tmo_q       <= tmo_d;
      tmo_cfg_q   <= tmo_cfg_d;
      trig_prev_q <= trigger;
      trig_addr   <= trig_addr_d;
      trig_forced <= trig_forced_d;
      capture_en  <= (state_d == ST_PRE) || (state_d == ST_WAIT) || (state_d == ST_POST);
      done        <= (state_d == ST_DONE);
      busy        <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_acq_trigger_ctrl.sv
// Scoreboard bench for acq_trigger_ctrl: directed scenarios queue the expected
// state transitions; a negedge monitor checks each transition as it happens.
module tb_acq_trigger_ctrl;
  import acq_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [CW-1:0] pre_samples = '0;
  logic [CW-1:0] post_samples = '0;
  logic [31:0]   auto_timeout = '0;
  logic          in_data_valid = 1'b0;
  logic          trigger = 1'b0;
  logic [AW-1:0] in_dma_master_address = '0;
  logic          done_ack = 1'b0;
  logic          capture_en;
  logic [AW-1:0] trig_addr;
  logic          trig_forced;
  logic          done;
  logic          busy;
  logic [2:0]    state;

  acq_trigger_ctrl #(.MEMORY_ADDR_LEN(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort), .mode(mode),
    .pre_samples(pre_samples), .post_samples(post_samples), .auto_timeout(auto_timeout),
    .in_data_valid(in_data_valid), .trigger(trigger),
    .in_dma_master_address(in_dma_master_address), .done_ack(done_ack),
    .capture_en(capture_en), .trig_addr(trig_addr), .trig_forced(trig_forced),
    .done(done), .busy(busy), .state(state)
  );

  always #5 clk = ~clk;

  // Expected snapshot on entry to a state; dwell/vals describe the state just left (-1 = don't care).
  typedef struct {
    logic [2:0]    st;
    logic          cap;
    logic          dn;
    logic          bsy;
    logic          frc;
    logic [AW-1:0] addr;
    int            dwell;
    int            vals;
  } obs_t;

  obs_t       exp_q[$];
  obs_t       mon_e;
  int         errors = 0;
  int         checks = 0;
  int         dwell_cnt = 0;
  int         val_cnt = 0;
  logic [2:0] prev_st = 3'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [2:0] st, input logic cap, input logic dn, input logic bsy,
                          input logic frc, input logic [AW-1:0] addr, input int dwell, input int vals);
    obs_t e;
    e.st = st; e.cap = cap; e.dn = dn; e.bsy = bsy; e.frc = frc;
    e.addr = addr; e.dwell = dwell; e.vals = vals;
    exp_q.push_back(e);
  endtask

  task automatic tick(input logic v, input logic t);
    in_data_valid = v;
    trigger = t;
    @(posedge clk);
    #1;
    arm = 1'b0;
    abort = 1'b0;
    done_ack = 1'b0;
  endtask

  // Monitor: every observed state change is matched against the head of the queue.
  always @(negedge clk) begin
    if (state !== prev_st) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_transition: got state %0d expected no transition", state);
      end else begin
        mon_e = exp_q.pop_front();
        chk("state", 64'(state), 64'(mon_e.st));
        chk("capture_en", 64'(capture_en), 64'(mon_e.cap));
        chk("done", 64'(done), 64'(mon_e.dn));
        chk("busy", 64'(busy), 64'(mon_e.bsy));
        chk("trig_forced", 64'(trig_forced), 64'(mon_e.frc));
        chk("trig_addr", 64'(trig_addr), 64'(mon_e.addr));
        if (mon_e.dwell >= 0) chk("dwell_prev_state", 64'(dwell_cnt), 64'(mon_e.dwell));
        if (mon_e.vals >= 0)  chk("valids_prev_state", 64'(val_cnt), 64'(mon_e.vals));
      end
      dwell_cnt = 0;
      val_cnt = 0;
    end
    dwell_cnt++;
    if (in_data_valid && capture_en) val_cnt++;
    prev_st = state;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values while rst is held.
    #12;
    chk("rst_state", 64'(state), 64'(0));
    chk("rst_capture_en", 64'(capture_en), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_trig_addr", 64'(trig_addr), 64'(0));
    @(posedge clk); #1 rst = 1'b0;

    // Single mode, pre=4, post=8, trigger edge after 10 valids at 0x100.
    mode = 2'd0; pre_samples = 16'd4; post_samples = 16'd8; in_dma_master_address = 32'h100;
    push_exp(3'd1, 1, 0, 1, 0, 32'h0,   -1, -1);
    push_exp(3'd2, 1, 0, 1, 0, 32'h0,    4,  4);
    push_exp(3'd3, 1, 0, 1, 0, 32'h100,  7,  7);
    push_exp(3'd4, 0, 1, 1, 0, 32'h100, 15,  8);
    push_exp(3'd0, 0, 0, 0, 0, 32'h100,  6,  0);
    arm = 1'b1; tick(0, 0);
    repeat (10) tick(1, 0);
    tick(1, 1);
    for (int i = 0; i < 20; i++) tick(1'(i % 2 == 0), 0);
    done_ack = 1'b1; tick(0, 0);
    repeat (2) tick(0, 0);

    // Trigger held high across arm and PRE: only a fresh edge is accepted.
    pre_samples = 16'd3; post_samples = 16'd2; in_dma_master_address = 32'h200;
    push_exp(3'd1, 1, 0, 1, 0, 32'h100, -1, -1);
    push_exp(3'd2, 1, 0, 1, 0, 32'h100,  3,  3);
    push_exp(3'd3, 1, 0, 1, 0, 32'h240,  6,  6);
    push_exp(3'd4, 0, 1, 1, 0, 32'h240,  2,  2);
    push_exp(3'd0, 0, 0, 0, 0, 32'h240,  1,  0);
    arm = 1'b1; tick(0, 1);
    repeat (3) tick(1, 1);
    repeat (3) tick(1, 1);
    repeat (2) tick(1, 0);
    in_dma_master_address = 32'h240; tick(1, 1);
    repeat (2) tick(1, 0);
    done_ack = 1'b1; tick(0, 0);

    // Auto mode, pre=0, timeout 50: forced trigger, then re-arm into PRE.
    mode = 2'd2; pre_samples = 16'd0; post_samples = 16'd1; auto_timeout = 32'd50;
    in_dma_master_address = 32'h300;
    push_exp(3'd2, 1, 0, 1, 0, 32'h240, -1, -1);
    push_exp(3'd3, 1, 0, 1, 1, 32'h300, 50,  0);
    push_exp(3'd4, 0, 1, 1, 1, 32'h300,  3,  1);
    push_exp(3'd1, 1, 0, 1, 1, 32'h300,  3,  0);
    arm = 1'b1; tick(0, 0);
    for (int i = 0; i < 55; i++) tick(1'(i == 52), 0);
    pre_samples = 16'd2; done_ack = 1'b1; tick(0, 0);

    // Abort coinciding with done_ack in POST: IDLE, done never raised.
    in_dma_master_address = 32'h400;
    push_exp(3'd2, 1, 0, 1, 1, 32'h300, 2, 2);
    push_exp(3'd3, 1, 0, 1, 0, 32'h400, 2, 0);
    push_exp(3'd0, 0, 0, 0, 0, 32'h400, 2, 1);
    repeat (2) tick(1, 0);
    tick(0, 0);
    tick(0, 1);
    tick(0, 1);
    abort = 1'b1; done_ack = 1'b1; tick(1, 1);
    repeat (3) tick(0, 0);
    arm = 1'b1; abort = 1'b1; tick(0, 0);
    repeat (2) tick(0, 0);

    // Normal mode: done_ack re-arms straight into PRE with busy held.
    mode = 2'd1; pre_samples = 16'd1; post_samples = 16'd1; auto_timeout = 32'd0;
    in_dma_master_address = 32'h500;
    push_exp(3'd1, 1, 0, 1, 0, 32'h400, -1, -1);
    push_exp(3'd2, 1, 0, 1, 0, 32'h400,  1,  1);
    push_exp(3'd3, 1, 0, 1, 0, 32'h500,  2,  0);
    push_exp(3'd4, 0, 1, 1, 0, 32'h500,  1,  1);
    push_exp(3'd1, 1, 0, 1, 0, 32'h500,  1,  0);
    arm = 1'b1; tick(0, 0);
    tick(1, 0);
    tick(0, 0);
    tick(0, 1);
    tick(1, 0);
    done_ack = 1'b1; tick(0, 0);

    // Asynchronous reset mid-POST, then a fresh arm after release.
    in_dma_master_address = 32'h600;
    push_exp(3'd2, 1, 0, 1, 0, 32'h500,  1,  1);
    push_exp(3'd3, 1, 0, 1, 0, 32'h600,  2,  0);
    push_exp(3'd0, 0, 0, 0, 0, 32'h0,   -1, -1);
    push_exp(3'd1, 1, 0, 1, 0, 32'h0,   -1, -1);
    push_exp(3'd0, 0, 0, 0, 0, 32'h0,    2,  0);
    tick(1, 0);
    tick(0, 0);
    tick(0, 1);
    tick(0, 0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_state", 64'(state), 64'(0));
    chk("async_rst_capture_en", 64'(capture_en), 64'(0));
    chk("async_rst_busy", 64'(busy), 64'(0));
    chk("async_rst_done", 64'(done), 64'(0));
    chk("async_rst_trig_forced", 64'(trig_forced), 64'(0));
    chk("async_rst_trig_addr", 64'(trig_addr), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mode = 2'd0;
    repeat (2) tick(0, 0);
    arm = 1'b1; tick(0, 0);
    tick(0, 0);
    abort = 1'b1; tick(0, 0);
    repeat (3) tick(0, 0);

    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
